// File: rtl/id_imm_ctrl_if.sv
// Decode-to-execute immediate bus: instruction handshake in, decoded immediate handshake out.
interface id_imm_ctrl_if;
  logic [31:0] iInstr;
  logic        iValid;
  logic        oReady;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  logic [31:0] oImm;
  logic [2:0]  oKind;
  logic [5:0]  oOp;

  modport master (
    output iInstr, iValid, iFlush, iReady,
    input  oReady, oValid, oImm, oKind, oOp
  );

  modport slave (
    input  iInstr, iValid, iFlush, iReady,
    output oReady, oValid, oImm, oKind, oOp
  );
endinterface

// File: rtl/id_imm_ctrl.sv
// Decode-stage immediate controller: classifies the opcode, forms the 32-bit immediate
// and queues it in a 2-entry skid buffer so hazard stalls never drop an immediate.
module id_imm_ctrl #(
  parameter int DEPTH = 2
) (
  input logic          iClk,
  input logic          iRst_n,
  id_imm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    KIND_NONE   = 3'd0,
    KIND_SIGN   = 3'd1,
    KIND_ZERO   = 3'd2,
    KIND_LUI    = 3'd3,
    KIND_BRANCH = 3'd4
  } kind_e;

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [5:0]  dec_op;
  logic [15:0] dec_field;
  kind_e       dec_kind;
  logic [31:0] dec_imm;

  logic [31:0] imm_mem  [2];
  logic [2:0]  kind_mem [2];
  logic [5:0]  op_mem   [2];
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] last_imm;
  logic [2:0]  last_kind;
  logic [5:0]  last_op;
  logic        push;
  logic        pop;

  assign dec_op    = bus.iInstr[31:26];
  assign dec_field = bus.iInstr[15:0];

  always_comb begin
    dec_kind = KIND_NONE;
    dec_imm  = 32'h0;
    case (dec_op)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        dec_kind = KIND_SIGN;
        dec_imm  = {{16{dec_field[15]}}, dec_field};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_kind = KIND_ZERO;
        dec_imm  = {16'h0, dec_field};
      end
      6'h0F: begin
        dec_kind = KIND_LUI;
        dec_imm  = {dec_field, 16'h0};
      end
      6'h04, 6'h05: begin
        dec_kind = KIND_BRANCH;
        dec_imm  = {{14{dec_field[15]}}, dec_field, 2'b00};
      end
      default: begin
        dec_kind = KIND_NONE;
        dec_imm  = 32'h0;
      end
    endcase
  end

  // Readiness depends on registered occupancy only, so iReady never reaches oReady.
  assign bus.oReady = (count != FULL);
  assign bus.oValid = (count != 2'd0);
  assign push       = bus.iValid & bus.oReady & ~bus.iFlush;
  assign pop        = bus.oValid & bus.iReady & ~bus.iFlush;

  assign bus.oImm   = bus.oValid ? imm_mem[rd_ptr]  : last_imm;
  assign bus.oKind  = bus.oValid ? kind_mem[rd_ptr] : last_kind;
  assign bus.oOp    = bus.oValid ? op_mem[rd_ptr]   : last_op;

  // The last popped entry is kept so the outputs hold steady while the buffer is empty.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 2; i++) begin
        imm_mem[i]  <= 32'h0;
        kind_mem[i] <= 3'd0;
        op_mem[i]   <= 6'd0;
      end
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      last_imm  <= 32'h0;
      last_kind <= 3'd0;
      last_op   <= 6'd0;
    end else if (bus.iFlush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        imm_mem[wr_ptr]  <= dec_imm;
        kind_mem[wr_ptr] <= dec_kind;
        op_mem[wr_ptr]   <= dec_op;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        last_imm  <= imm_mem[rd_ptr];
        last_kind <= kind_mem[rd_ptr];
        last_op   <= op_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Self-checking bench for id_imm_ctrl: table of hand-decoded instructions fed through
// a queue-based scoreboard, plus directed stall, flush and async-reset sequences.
module tb_id_imm_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  kind;
    logic [5:0]  op;
  } vec_t;

  logic iClk;
  logic iRst_n;
  id_imm_ctrl_if bus ();

  id_imm_ctrl #(.DEPTH(2)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  vec_t vecs [14];
  vec_t expQ [$];
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called between edges: the model queue mirrors what the buffer should hold now.
  task automatic checkOutput(input logic ready, input logic flush);
    cmp("oReady", 32'(bus.oReady), 32'(expQ.size() != 2));
    cmp("oValid", 32'(bus.oValid), 32'(expQ.size() != 0));
    if (ready && !flush && expQ.size() != 0) begin
      cmp("oImm",  bus.oImm,        expQ[0].imm);
      cmp("oKind", 32'(bus.oKind),  32'(expQ[0].kind));
      cmp("oOp",   32'(bus.oOp),    32'(expQ[0].op));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic valid, input logic ready, input logic flush);
    bit doPush;
    bit doPop;
    bus.iInstr = v.instr;
    bus.iValid = valid;
    bus.iReady = ready;
    bus.iFlush = flush;
    @(negedge iClk);
    checkOutput(ready, flush);
    doPush = valid && (expQ.size() < 2) && !flush;
    doPop  = ready && (expQ.size() > 0) && !flush;
    @(posedge iClk);
    if (flush) expQ.delete();
    else begin
      if (doPop)  void'(expQ.pop_front());
      if (doPush) expQ.push_back(v);
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ready);
    repeat (n) applyStimulus(vecs[4], 1'b0, ready, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{32'h2008FFFF, 32'hFFFFFFFF, 3'd1, 6'h08};
    vecs[1]  = '{32'h35088000, 32'h00008000, 3'd2, 6'h0D};
    vecs[2]  = '{32'h3C011234, 32'h12340000, 3'd3, 6'h0F};
    vecs[3]  = '{32'h1000FFFE, 32'hFFFFFFF8, 3'd4, 6'h04};
    vecs[4]  = '{32'h00000020, 32'h00000000, 3'd0, 6'h00};
    vecs[5]  = '{32'h3108ABCD, 32'h0000ABCD, 3'd2, 6'h0C};
    vecs[6]  = '{32'h8C011234, 32'h00001234, 3'd1, 6'h23};
    vecs[7]  = '{32'hAC01FFF0, 32'hFFFFFFF0, 3'd1, 6'h2B};
    vecs[8]  = '{32'h14017FFF, 32'h0001FFFC, 3'd4, 6'h05};
    vecs[9]  = '{32'h08000010, 32'h00000000, 3'd0, 6'h02};
    vecs[10] = '{32'h28018000, 32'hFFFF8000, 3'd1, 6'h0A};
    vecs[11] = '{32'h380100FF, 32'h000000FF, 3'd2, 6'h0E};
    vecs[12] = '{32'h2C010001, 32'h00000001, 3'd1, 6'h0B};
    vecs[13] = '{32'h24018001, 32'hFFFF8001, 3'd1, 6'h09};

    bus.iInstr = 32'h0;
    bus.iValid = 1'b0;
    bus.iReady = 1'b0;
    bus.iFlush = 1'b0;
    iRst_n     = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    cmp("rst oValid", 32'(bus.oValid), 32'h0);
    cmp("rst oReady", 32'(bus.oReady), 32'h1);
    cmp("rst oImm",   bus.oImm,        32'h0);
    cmp("rst oKind",  32'(bus.oKind),  32'h0);
    cmp("rst oOp",    32'(bus.oOp),    32'h0);
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;

    $display("[TB] decode table, back-to-back with iReady=1");
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    $display("[TB] stall and fill");
    applyStimulus(vecs[1], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[2], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[3], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[3], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[3], 1'b1, 1'b1, 1'b0);
    applyStimulus(vecs[3], 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    $display("[TB] steady push/pop at occupancy 1");
    applyStimulus(vecs[5], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(vecs[(i + 6) % 14], 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    $display("[TB] flush while full with incoming instruction");
    applyStimulus(vecs[7], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[8], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[9], 1'b1, 1'b1, 1'b1);
    applyStimulus(vecs[10], 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(vecs[$urandom_range(0, 13)], $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    idle(2, 1'b1);

    $display("[TB] async reset while full");
    applyStimulus(vecs[11], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[0], 1'b1, 1'b0, 1'b0);
    bus.iValid = 1'b0;
    cmp("pre-rst oValid", 32'(bus.oValid), 32'h1);
    #2;
    iRst_n = 1'b0;
    #1;
    cmp("async oValid", 32'(bus.oValid), 32'h0);
    cmp("async oImm",   bus.oImm,        32'h0);
    cmp("async oReady", 32'(bus.oReady), 32'h1);
    expQ.delete();
    @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    applyStimulus(vecs[13], 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
